// File: rtl/prga_encrypt_stream.sv
// RC4 PRGA stream encryptor: XORs a handshaked plaintext stream with the RC4 keystream and
// writes a length-prefixed ciphertext image (ct[0] = length, ct[1..len] = ciphertext).
module prga_encrypt_stream #(
    parameter int unsigned MAX_LEN = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    input  logic [7:0] pt_data,
    input  logic       pt_valid,
    input  logic       pt_last,
    output logic       pt_ready,
    output logic [7:0] ct_addr,
    output logic [7:0] ct_wrdata,
    output logic       ct_wren,
    output logic       trunc
);

    localparam logic [7:0] MaxLen = 8'(MAX_LEN);

    typedef enum logic [3:0] {
        StIdle, StRdI, StLatI, StRdJ, StLatJ, StWrI, StWrJ,
        StRdP, StLatP, StWaitPt, StWrLen, StDone
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [7:0] si_q, si_d, sj_q, sj_d, pad_q, pad_d;
    logic       rdy_q, rdy_d, trunc_q, trunc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            k_q     <= 8'd1;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            pad_q   <= 8'd0;
            rdy_q   <= 1'b1;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            pad_q   <= pad_d;
            rdy_q   <= rdy_d;
            trunc_q <= trunc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        si_d      = si_q;
        sj_d      = sj_q;
        pad_d     = pad_q;
        rdy_d     = rdy_q;
        trunc_d   = trunc_q;
        s_addr    = 8'd0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        pt_ready  = 1'b0;
        ct_addr   = 8'd0;
        ct_wrdata = 8'd0;
        ct_wren   = 1'b0;

        case (state_q)
            StIdle: begin
                if (en) begin
                    i_d     = 8'd1;
                    j_d     = 8'd0;
                    k_d     = 8'd1;
                    trunc_d = 1'b0;
                    rdy_d   = 1'b0;
                    state_d = StRdI;
                end
            end
            StRdI: begin
                s_addr  = i_q;
                state_d = StLatI;
            end
            StLatI: begin
                s_addr  = i_q;
                si_d    = s_rddata;
                j_d     = j_q + s_rddata;
                state_d = StRdJ;
            end
            StRdJ: begin
                s_addr  = j_q;
                state_d = StLatJ;
            end
            StLatJ: begin
                s_addr  = j_q;
                sj_d    = s_rddata;
                state_d = StWrI;
            end
            StWrI: begin
                s_addr   = i_q;
                s_wrdata = sj_q;
                s_wren   = 1'b1;
                state_d  = StWrJ;
            end
            StWrJ: begin
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                state_d  = StRdP;
            end
            StRdP: begin
                s_addr  = si_q + sj_q;
                state_d = StLatP;
            end
            StLatP: begin
                s_addr  = si_q + sj_q;
                pad_d   = s_rddata;
                state_d = StWaitPt;
            end
            StWaitPt: begin
                // Keystream byte is already in pad, so the write happens in the handshake cycle
                pt_ready  = 1'b1;
                ct_addr   = k_q;
                ct_wrdata = pad_q ^ pt_data;
                ct_wren   = pt_valid;
                if (pt_valid) begin
                    if (pt_last) begin
                        state_d = StWrLen;
                    end else if (k_q == MaxLen) begin
                        trunc_d = 1'b1;
                        state_d = StWrLen;
                    end else begin
                        i_d     = i_q + 8'd1;
                        k_d     = k_q + 8'd1;
                        state_d = StRdI;
                    end
                end
            end
            StWrLen: begin
                ct_addr   = 8'd0;
                ct_wrdata = k_q;
                ct_wren   = 1'b1;
                state_d   = StDone;
            end
            StDone: begin
                rdy_d   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign rdy   = rdy_q;
    assign trunc = trunc_q;

endmodule

// File: tb/tb_prga_encrypt_stream.sv
// Randomised bench for prga_encrypt_stream: plain RC4 model plus S/ct memory models.
module tb_prga_encrypt_stream;
    localparam int unsigned MAX_LEN = 255;

    logic       clk = 1'b0;
    logic       rst, en, rdy;
    logic [7:0] s_addr, s_rddata, s_wrdata;
    logic       s_wren;
    logic [7:0] pt_data;
    logic       pt_valid, pt_last, pt_ready;
    logic [7:0] ct_addr, ct_wrdata;
    logic       ct_wren, trunc;

    always #5 clk = ~clk;

    prga_encrypt_stream #(.MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy),
        .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
        .pt_data(pt_data), .pt_valid(pt_valid), .pt_last(pt_last), .pt_ready(pt_ready),
        .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren), .trunc(trunc)
    );

    logic [7:0] s_mem  [256];
    logic [7:0] ct_mem [256];
    logic [7:0] ksa_s  [256];
    logic [7:0] exp_ct [256];
    logic [7:0] key    [16];
    logic [7:0] msg    [512];
    logic [7:0] lit_ct [10];
    int         key_len, exp_len, ct_wr_cnt;
    logic       load_req, checking;
    int         n_pass = 0, n_total = 0;

    // Memories: synchronous-read S, write-only ct; load_req restores S and scrubs ct
    always @(posedge clk) begin
        if (load_req) begin
            for (int a = 0; a < 256; a++) begin
                s_mem[a]  <= ksa_s[a];
                ct_mem[a] <= 8'h5A;
            end
            ct_wr_cnt <= 0;
        end else begin
            if (s_wren) s_mem[s_addr] <= s_wrdata;
            if (ct_wren) begin
                ct_mem[ct_addr] <= ct_wrdata;
                ct_wr_cnt       <= ct_wr_cnt + 1;
            end
        end
        s_rddata <= s_mem[s_addr];
    end

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic do_ksa();
        int j = 0;
        logic [7:0] t;
        for (int i = 0; i < 256; i++) ksa_s[i] = 8'(i);
        for (int i = 0; i < 256; i++) begin
            j = (j + int'(ksa_s[i]) + int'(key[i % key_len])) % 256;
            t = ksa_s[i]; ksa_s[i] = ksa_s[j]; ksa_s[j] = t;
        end
    endtask

    task automatic build_model(input int n_enc);
        logic [7:0] sm [256];
        logic [7:0] t;
        int i = 0, j = 0;
        for (int a = 0; a < 256; a++) sm[a] = ksa_s[a];
        for (int b = 0; b < n_enc; b++) begin
            i = (i + 1) % 256;
            j = (j + int'(sm[i])) % 256;
            t = sm[i]; sm[i] = sm[j]; sm[j] = t;
            exp_ct[b + 1] = msg[b] ^ sm[(int'(sm[i]) + int'(sm[j])) % 256];
        end
        exp_ct[0] = 8'(n_enc);
        exp_len   = n_enc;
    endtask

    // Every ciphertext write the DUT makes must match the model
    always @(negedge clk) begin
        if (!rst && checking) begin
            if (ct_wren) begin
                if (ct_addr == 8'd0)
                    check(ct_wrdata == exp_ct[0], "len_write", ct_wrdata, exp_ct[0]);
                else
                    check(int'(ct_addr) <= exp_len && ct_wrdata == exp_ct[ct_addr], "ct_write",
                          ct_wrdata, exp_ct[ct_addr]);
                check(!s_wren, "wren_exclusive", s_wren, 0);
            end
            if (pt_valid && pt_ready) check(ct_wren, "ct_wren_on_accept", ct_wren, 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_key(input string k);
        key_len = k.len();
        for (int a = 0; a < key_len; a++) key[a] = k[a];
        do_ksa();
    endtask

    task automatic set_msg(input string m);
        for (int a = 0; a < m.len(); a++) msg[a] = m[a];
    endtask

    task automatic start_run();
        bit ok = 0;
        for (int c = 0; c < 100; c++) begin
            if (rdy) begin ok = 1; break; end
            tick();
        end
        check(ok, "rdy_before_start", rdy, 1);
        en = 1'b1;
        tick();
        en = 1'b0;
        check(rdy == 1'b0, "rdy_drops", rdy, 0);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last, input int gap, input bit spam,
                             output bit acc);
        pt_valid = 1'b0;
        pt_data  = 8'($urandom);
        pt_last  = 1'($urandom);
        repeat (gap) tick();
        pt_valid = 1'b1;
        pt_data  = d;
        pt_last  = last;
        acc      = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (spam) en = 1'($urandom);
            if (pt_ready) acc = 1;
            tick();
            if (acc) break;
        end
        pt_valid = 1'b0;
        pt_last  = 1'b0;
        en       = 1'b0;
    endtask

    // gap < 0 selects a random 0..3 cycle idle gap before each byte
    task automatic run_msg(input int n_send, input bit has_last, input int gap, input bit spam);
        int n_enc, viol, g;
        bit acc, ok;
        n_enc = (!has_last && n_send > int'(MAX_LEN)) ? int'(MAX_LEN) : n_send;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        build_model(n_enc);
        checking = 1'b1;
        start_run();
        for (int b = 0; b < n_enc; b++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            send_byte(msg[b], has_last && (b == n_send - 1), g, spam, acc);
            check(acc, "byte_accepted", acc, 1);
            if (!acc) break;
        end
        if (n_send > n_enc) begin
            viol     = 0;
            pt_valid = 1'b1;
            pt_data  = msg[n_enc];
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (pt_ready) viol++;
                tick();
            end
            pt_valid = 1'b0;
            check(viol == 0, "no_ready_after_max", viol, 0);
        end
        ok = 0;
        for (int c = 0; c < 40; c++) begin
            if (rdy) begin ok = 1; break; end
            tick();
        end
        check(ok, "rdy_returns", rdy, 1);
        check(ct_mem[0] == exp_ct[0], "ct_len", ct_mem[0], exp_ct[0]);
        for (int k = 1; k <= exp_len; k++)
            check(ct_mem[k] == exp_ct[k], "ct_mem", ct_mem[k], exp_ct[k]);
        check(trunc == (n_send > n_enc), "trunc", trunc, int'(n_send > n_enc));
        check(ct_wr_cnt == exp_len + 1, "ct_wren_pulses", ct_wr_cnt, exp_len + 1);
        checking = 1'b0;
    endtask

    task automatic check_lit(input string name);
        for (int k = 1; k <= 9; k++) begin
            check(ct_mem[k] == lit_ct[k], name, ct_mem[k], lit_ct[k]);
            check(exp_ct[k] == lit_ct[k], "model_vs_literal", exp_ct[k], lit_ct[k]);
        end
    endtask

    initial begin
        bit acc;
        int n;
        lit_ct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        rst = 1'b1; en = 1'b0; pt_valid = 1'b0; pt_last = 1'b0; pt_data = 8'd0;
        load_req = 1'b0; checking = 1'b0; exp_len = 0;
        set_key("Key");
        tick(); tick();
        check(rdy == 1'b1 && pt_ready == 1'b0 && trunc == 1'b0, "reset_flags", rdy, 1);
        check(s_wren == 0 && ct_wren == 0 && s_addr == 0 && ct_addr == 0 && s_wrdata == 0
              && ct_wrdata == 0, "reset_outputs", ct_wren, 0);
        rst = 1'b0;
        tick();

        // Known-answer vector, back-to-back and with idle gaps
        set_msg("Plaintext");
        run_msg(9, 1, 0, 0);
        check(ct_mem[0] == lit_ct[0], "kat_len", ct_mem[0], lit_ct[0]);
        check_lit("kat_ct");
        run_msg(9, 1, 5, 0);
        check_lit("kat_gap_ct");

        msg[0] = 8'h00;
        run_msg(1, 1, 2, 0);
        check(ct_mem[0] == 8'h01 && ct_mem[1] == 8'hEB, "single_byte", ct_mem[1], 8'hEB);

        // Truncation: 300 bytes with no pt_last
        for (int a = 0; a < 300; a++) msg[a] = 8'($urandom);
        run_msg(300, 0, 0, 0);
        check(ct_mem[0] == 8'hFF && trunc == 1'b1, "trunc_len", ct_mem[0], 8'hFF);

        // Asynchronous reset after byte 3
        set_msg("Plaintext");
        load_req = 1'b1; tick(); load_req = 1'b0;
        build_model(9);
        checking = 1'b1;
        start_run();
        for (int b = 0; b < 3; b++) send_byte(msg[b], 0, 1, 0, acc);
        tick(); tick();
        rst = 1'b1;
        #2;
        check(rdy == 1'b1 && pt_ready == 1'b0 && trunc == 1'b0 && s_wren == 1'b0
              && ct_wren == 1'b0 && s_addr == 8'd0, "async_reset", rdy, 1);
        tick(); tick();
        check(ct_wr_cnt == 3, "no_writes_after_abort", ct_wr_cnt, 3);
        rst = 1'b0;
        checking = 1'b0;
        tick();
        run_msg(9, 1, 0, 0);
        check_lit("post_reset_ct");

        // en hammered while busy
        run_msg(9, 1, 2, 1);
        check_lit("en_spam_ct");

        // Random keys and messages
        for (int r = 0; r < 4; r++) begin
            key_len = int'($urandom_range(1, 16));
            for (int a = 0; a < key_len; a++) key[a] = 8'($urandom);
            do_ksa();
            n = int'($urandom_range(1, 40));
            for (int a = 0; a < n; a++) msg[a] = 8'($urandom);
            run_msg(n, 1, -1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
